// File: rtl/predictor_pkg.sv
// predictor_pkg: jump-kind encodings and the return-stack checkpoint record.
// Checkpoint fields are sized for the largest supported configuration
// (DEPTH up to 128, addresses up to 64 bits). Instances use only the low bits.
package predictor_pkg;
    localparam logic [2:0] NOT_JUMP      = 3'd0;
    localparam logic [2:0] DIRECT_JUMP   = 3'd1;
    localparam logic [2:0] RET           = 3'd4;
    localparam logic [2:0] INDIRECT_JUMP = 3'd5;
    localparam logic [2:0] CALL          = 3'd6;
    localparam logic [2:0] JUMP          = 3'd7;
    localparam int CKPT_TOS_W = 8;
    localparam int CKPT_CNT_W = 9;
    localparam int CKPT_TOP_W = 64;
    typedef struct packed {
        logic [CKPT_TOS_W-1:0] tos;
        logic [CKPT_CNT_W-1:0] cnt;
        logic [CKPT_TOP_W-1:0] top;
    } ckpt_t;
endpackage

// File: rtl/ras_ckpt_queue.sv
// ras_ckpt_queue: ring of return-stack checkpoints, one per in-flight jump.
// Ports: clk, rstn (sync, active-low); alloc/alloc_data write the tail slot;
// retire frees the head slot; recover/recover_id flush every slot from
// recover_id onward and expose that slot on recover_data; tail_id is the next
// slot to be allocated; full/empty are decoded from the registered pointers.
module ras_ckpt_queue
    import predictor_pkg::*;
#(
    parameter int CKPT_NUM = 8,
    localparam int IW = $clog2(CKPT_NUM)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          alloc,
    input  ckpt_t         alloc_data,
    input  logic          retire,
    input  logic          recover,
    input  logic [IW-1:0] recover_id,
    output ckpt_t         recover_data,
    output logic [IW-1:0] tail_id,
    output logic          full,
    output logic          empty
);
    // One extra wrap bit on each pointer separates full from empty.
    logic [IW:0] head, tail;
    ckpt_t ring [CKPT_NUM];
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < CKPT_NUM; i++) ring[i] <= '0;
        end else if (recover) begin
            head <= {1'b0, recover_id} + 1'b1;
            tail <= {1'b0, recover_id} + 1'b1;
        end else begin
            if (alloc) begin
                ring[tail[IW-1:0]] <= alloc_data;
                tail <= tail + 1'b1;
            end
            if (retire) head <= head + 1'b1;
        end
    end
    assign recover_data = ring[recover_id];
    assign tail_id      = tail[IW-1:0];
    assign full         = (tail - head) == (IW+1)'(CKPT_NUM);
    assign empty        = head == tail;
endmodule

// File: rtl/ras_spec.sv
// ras_spec: speculative return-address stack with per-jump checkpoints.
// Ports: clk, rstn (sync, active-low); stall, pdc_valid/pdc_kind/pdc_ret_pc
// from fetch; ret_pdc/ret_valid top of stack; ckpt_id/ckpt_full/ckpt_empty
// checkpoint status; ex_valid/ex_ckpt_id/ex_mis/ex_kind/ex_ret_pc resolve the
// oldest jump. Define RAS_STATS_EN to add 32-bit counters cnt_push,
// cnt_overflow, cnt_pop_empty and cnt_recover.
module ras_spec
    import predictor_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int DEPTH      = 16,
    parameter int CKPT_NUM   = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(CKPT_NUM)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  stall,
    input  logic                  pdc_valid,
    input  logic [2:0]            pdc_kind,
    input  logic [ADDR_WIDTH-1:0] pdc_ret_pc,
    output logic [ADDR_WIDTH-1:0] ret_pdc,
    output logic                  ret_valid,
    output logic [IW-1:0]         ckpt_id,
    output logic                  ckpt_full,
    output logic                  ckpt_empty,
`ifdef RAS_STATS_EN
    output logic [31:0]           cnt_push,
    output logic [31:0]           cnt_overflow,
    output logic [31:0]           cnt_pop_empty,
    output logic [31:0]           cnt_recover,
`endif
    input  logic                  ex_valid,
    input  logic [IW-1:0]         ex_ckpt_id,
    input  logic                  ex_mis,
    input  logic [2:0]            ex_kind,
    input  logic [ADDR_WIDTH-1:0] ex_ret_pc
);
    logic [ADDR_WIDTH-1:0] stack [DEPTH];
    logic [PW-1:0] tos, base_tos, next_tos;
    logic [CW-1:0] cnt, base_cnt, next_cnt;
    logic [2:0] kind;
    logic [ADDR_WIDTH-1:0] push_pc;
    logic recover, fire, act, eff_call, eff_ret;
    ckpt_t snap, rd;
    logic ckpt_unused;
    // A recover replays the real kind on top of the restored state; otherwise
    // the fetch-side prediction is applied to the live state.
    always_comb begin
        recover  = ex_valid && ex_mis;
        fire     = pdc_valid && !stall && !ckpt_full && !recover && pdc_kind != NOT_JUMP;
        act      = recover || fire;
        base_tos = recover ? PW'(rd.tos) : tos;
        base_cnt = recover ? CW'(rd.cnt) : cnt;
        kind     = recover ? ex_kind : pdc_kind;
        push_pc  = recover ? ex_ret_pc : pdc_ret_pc;
        eff_call = act && kind == CALL;
        eff_ret  = act && kind == RET && base_cnt != '0;
        next_tos = eff_call ? base_tos + 1'b1 : eff_ret ? base_tos - 1'b1 : base_tos;
        next_cnt = (eff_call && base_cnt != CW'(DEPTH)) ? base_cnt + 1'b1 : eff_ret ? base_cnt - 1'b1 : base_cnt;
        snap     = '{tos: CKPT_TOS_W'(tos), cnt: CKPT_CNT_W'(cnt), top: CKPT_TOP_W'(stack[tos])};
    end
    // Checkpoint fields wider than this configuration are always zero.
    assign ckpt_unused = ^rd;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            tos <= '0;
            cnt <= '0;
        end else begin
            if (recover) stack[PW'(rd.tos)] <= ADDR_WIDTH'(rd.top);
            if (eff_call) stack[next_tos] <= push_pc;
            tos <= next_tos;
            cnt <= next_cnt;
        end
    end
    assign ret_pdc   = stack[tos];
    assign ret_valid = cnt != '0;
    ras_ckpt_queue #(.CKPT_NUM(CKPT_NUM)) u_queue (
        .clk          (clk),
        .rstn         (rstn),
        .alloc        (fire),
        .alloc_data   (snap),
        .retire       (ex_valid && !ex_mis),
        .recover      (recover),
        .recover_id   (ex_ckpt_id),
        .recover_data (rd),
        .tail_id      (ckpt_id),
        .full         (ckpt_full),
        .empty        (ckpt_empty)
    );
`ifdef RAS_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_push      <= '0;
            cnt_overflow  <= '0;
            cnt_pop_empty <= '0;
            cnt_recover   <= '0;
        end else begin
            cnt_push      <= cnt_push + 32'(eff_call);
            cnt_overflow  <= cnt_overflow + 32'(eff_call && base_cnt == CW'(DEPTH));
            cnt_pop_empty <= cnt_pop_empty + 32'(act && kind == RET && base_cnt == '0);
            cnt_recover   <= cnt_recover + 32'(recover);
        end
    end
`endif
endmodule

// File: tb/tb_ras_spec.sv
// tb_ras_spec: directed vectors and corner-case sequences for ras_spec.
module tb_ras_spec;
    import predictor_pkg::*;
    logic        clk = 0, rstn = 0, stall = 0, pdc_valid = 0;
    logic [2:0]  pdc_kind = 0;
    logic [29:0] pdc_ret_pc = 0;
    logic [29:0] ret_pdc;
    logic        ret_valid, ckpt_full, ckpt_empty;
    logic [2:0]  ckpt_id;
    logic        ex_valid = 0, ex_mis = 0;
    logic [2:0]  ex_ckpt_id = 0, ex_kind = 0;
    logic [29:0] ex_ret_pc = 0;
`ifdef RAS_STATS_EN
    logic [31:0] cnt_push, cnt_overflow, cnt_pop_empty, cnt_recover;
`endif
    int checks = 0, failures = 0;
    logic [2:0] hd;

    ras_spec dut (
        .clk(clk), .rstn(rstn), .stall(stall), .pdc_valid(pdc_valid),
        .pdc_kind(pdc_kind), .pdc_ret_pc(pdc_ret_pc), .ret_pdc(ret_pdc),
        .ret_valid(ret_valid), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .ckpt_empty(ckpt_empty),
`ifdef RAS_STATS_EN
        .cnt_push(cnt_push), .cnt_overflow(cnt_overflow),
        .cnt_pop_empty(cnt_pop_empty), .cnt_recover(cnt_recover),
`endif
        .ex_valid(ex_valid), .ex_ckpt_id(ex_ckpt_id), .ex_mis(ex_mis),
        .ex_kind(ex_kind), .ex_ret_pc(ex_ret_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pv; logic [2:0] k; logic [29:0] pc;
        logic ev, mis; logic [2:0] ek, eid;
        logic [2:0] e_id; logic [29:0] e_ret; logic e_rv, e_empty, e_full;
    } vec_t;
    vec_t vt [17];

    function automatic vec_t mk(input logic pv, input logic [2:0] k, input logic [29:0] pc,
                                input logic ev, mis, input logic [2:0] ek, eid, e_id,
                                input logic [29:0] e_ret, input logic e_rv, e_empty, e_full);
        return '{pv, k, pc, ev, mis, ek, eid, e_id, e_ret, e_rv, e_empty, e_full};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic pv, input logic [2:0] k, input logic [29:0] pc,
                          input logic ev, mis, input logic [2:0] ek, eid, input logic [29:0] epc);
        pdc_valid = pv; pdc_kind = k; pdc_ret_pc = pc;
        ex_valid = ev; ex_mis = mis; ex_kind = ek; ex_ckpt_id = eid; ex_ret_pc = epc;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Fetch one jump, then retire it in the following cycle.
    task automatic op(input logic [2:0] k, input logic [29:0] pc);
        set_in(1, k, pc, 0, 0, 0, 0, 0);
        cyc();
        set_in(0, 0, 0, 1, 0, 0, hd, 0);
        cyc();
        hd = hd + 3'd1;
    endtask

    initial begin
        vt[0]  = mk(1, CALL, 30'h100, 0, 0, 0, 0, 0, 30'h100, 1, 0, 0);
        vt[1]  = mk(0, 0,    0,       1, 0, 0, 0, 1, 30'h100, 1, 1, 0);
        vt[2]  = mk(1, CALL, 30'h200, 0, 0, 0, 0, 1, 30'h200, 1, 0, 0);
        vt[3]  = mk(0, 0,    0,       1, 0, 0, 1, 2, 30'h200, 1, 1, 0);
        vt[4]  = mk(1, CALL, 30'h300, 0, 0, 0, 0, 2, 30'h300, 1, 0, 0);
        vt[5]  = mk(0, 0,    0,       1, 0, 0, 2, 3, 30'h300, 1, 1, 0);
        vt[6]  = mk(1, RET,  0,       0, 0, 0, 0, 3, 30'h200, 1, 0, 0);
        vt[7]  = mk(0, 0,    0,       1, 0, 0, 3, 4, 30'h200, 1, 1, 0);
        vt[8]  = mk(1, RET,  0,       0, 0, 0, 0, 4, 30'h100, 1, 0, 0);
        vt[9]  = mk(0, 0,    0,       1, 0, 0, 4, 5, 30'h100, 1, 1, 0);
        vt[10] = mk(1, RET,  0,       0, 0, 0, 0, 5, 30'h0,   0, 0, 0);
        vt[11] = mk(0, 0,    0,       1, 0, 0, 5, 6, 30'h0,   0, 1, 0);
        vt[12] = mk(1, CALL, 30'hA,   0, 0, 0, 0, 6, 30'hA,   1, 0, 0);
        vt[13] = mk(1, RET,  0,       0, 0, 0, 0, 7, 30'h0,   0, 0, 0);
        vt[14] = mk(1, CALL, 30'hB,   0, 0, 0, 0, 0, 30'hB,   1, 0, 0);
        vt[15] = mk(0, 0,    0,       1, 0, 0, 6, 1, 30'hB,   1, 0, 0);
        vt[16] = mk(0, 0,    0,       1, 1, 0, 7, 1, 30'hA,   1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ret_pdc", 32'(ret_pdc), 0);
        chk("rst_ret_valid", 32'(ret_valid), 0);
        chk("rst_ckpt_id", 32'(ckpt_id), 0);
        chk("rst_ckpt_full", 32'(ckpt_full), 0);
        chk("rst_ckpt_empty", 32'(ckpt_empty), 1);
        rstn = 1;

        for (int i = 0; i < 17; i++) begin
            set_in(vt[i].pv, vt[i].k, vt[i].pc, vt[i].ev, vt[i].mis, vt[i].ek, vt[i].eid, 0);
            #1;
            chk($sformatf("v%0d_ckpt_id", i), 32'(ckpt_id), 32'(vt[i].e_id));
            cyc();
            chk($sformatf("v%0d_ret_pdc", i), 32'(ret_pdc), 32'(vt[i].e_ret));
            chk($sformatf("v%0d_ret_valid", i), 32'(ret_valid), 32'(vt[i].e_rv));
            chk($sformatf("v%0d_empty", i), 32'(ckpt_empty), 32'(vt[i].e_empty));
            chk($sformatf("v%0d_full", i), 32'(ckpt_full), 32'(vt[i].e_full));
        end

        // Fill all checkpoint slots, then probe full-queue behaviour.
        for (int i = 0; i < 8; i++) begin
            set_in(1, DIRECT_JUMP, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("fill%0d_ckpt_id", i), 32'(ckpt_id), i);
            cyc();
        end
        chk("fill_full", 32'(ckpt_full), 1);
        set_in(1, CALL, 30'h99, 0, 0, 0, 0, 0);
        cyc();
        chk("ninth_ignored_full", 32'(ckpt_full), 1);
        chk("ninth_ignored_ret", 32'(ret_pdc), 30'hA);
        set_in(1, DIRECT_JUMP, 0, 1, 0, 0, 0, 0);
        cyc();
        chk("retire_frees_full", 32'(ckpt_full), 0);
        chk("retire_cycle_alloc_dropped", 32'(ckpt_id), 0);
        set_in(1, DIRECT_JUMP, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wrap_ckpt_id", 32'(ckpt_id), 0);
        cyc();
        chk("refill_full", 32'(ckpt_full), 1);
        set_in(0, 0, 0, 1, 1, DIRECT_JUMP, 1, 0);
        cyc();
        chk("flush_empty", 32'(ckpt_empty), 1);
        chk("flush_ckpt_id", 32'(ckpt_id), 2);
        chk("flush_ret", 32'(ret_pdc), 30'hA);

        // Recover and a fetch CALL in the same cycle.
        set_in(1, CALL, 30'hD, 0, 0, 0, 0, 0);
        cyc();
        chk("call_d_ret", 32'(ret_pdc), 30'hD);
        set_in(1, CALL, 30'hC, 1, 1, NOT_JUMP, 2, 0);
        cyc();
        chk("rec_fetch_ret", 32'(ret_pdc), 30'hA);
        chk("rec_fetch_ckpt_id", 32'(ckpt_id), 3);
        chk("rec_fetch_empty", 32'(ckpt_empty), 1);

        // Overflow: empty the stack, push 17, pop 16.
        hd = 3;
        op(RET, 0);
        chk("pre_ovf_empty_stack", 32'(ret_valid), 0);
        for (int i = 1; i <= 17; i++) op(CALL, 30'(i));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_pop%0d", i), 32'(ret_pdc), 32'h11 - 32'(i));
            op(RET, 0);
        end
        chk("ovf_drained", 32'(ret_valid), 0);
`ifdef RAS_STATS_EN
        chk("cnt_overflow", cnt_overflow, 1);
        chk("cnt_pop_empty_before", cnt_pop_empty, 0);
`endif

        // Pop on empty, then a single push.
        op(RET, 0);
        chk("pop_empty_valid", 32'(ret_valid), 0);
        op(CALL, 30'h5);
        chk("after_pop_empty_ret", 32'(ret_pdc), 30'h5);
        chk("after_pop_empty_valid", 32'(ret_valid), 1);
        op(RET, 0);
        chk("single_entry_popped", 32'(ret_valid), 0);
`ifdef RAS_STATS_EN
        chk("cnt_pop_empty", cnt_pop_empty, 1);
        chk("cnt_push", cnt_push, 24);
        chk("cnt_recover", cnt_recover, 3);
`endif

        // Reset arriving together with a recover.
        op(CALL, 30'h44);
        set_in(0, 0, 0, 1, 1, CALL, hd, 30'h77);
        rstn = 0;
        cyc();
        rstn = 1;
        chk("rst_rec_ret_pdc", 32'(ret_pdc), 0);
        chk("rst_rec_ret_valid", 32'(ret_valid), 0);
        chk("rst_rec_ckpt_id", 32'(ckpt_id), 0);
        chk("rst_rec_empty", 32'(ckpt_empty), 1);
        chk("rst_rec_full", 32'(ckpt_full), 0);
`ifdef RAS_STATS_EN
        chk("rst_cnt_push", cnt_push, 0);
        chk("rst_cnt_recover", cnt_recover, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ras_spec.md
# ras_spec

Speculative return-address stack for the branch predictor, with per-branch checkpoints for misprediction repair. It is a parametrised successor to the fixed-depth RAS inside the npc predictor: depth, checkpoint count and address width are configurable, and the stack overwrites its oldest entry on overflow. The fetch stage pushes and pops it speculatively. The ex stage retires or repairs it in program order.

## Interface
- ADDR_WIDTH, 30, word-address width of return addresses
- DEPTH, 16, stack entries (power of 2, ≥2)
- CKPT_NUM, 8, checkpoint slots (power of 2, ≥2)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- stall  in  1  freezes all fetch-side actions
- pdc_valid  in  1  fetch has a prediction this cycle
- pdc_kind  in  3  predicted kind (CALL=6 push, RET=4 pop, any non-zero allocates a checkpoint)
- pdc_ret_pc  in  ADDR_WIDTH  return address pushed on CALL
- ret_pdc  out  ADDR_WIDTH  current top-of-stack entry
- ret_valid  out  1  stack non-empty
- ckpt_id  out  log2(CKPT_NUM)  slot allocated to the current jump prediction
- ckpt_full  out  1  no free checkpoint slot; fetch must stall
- ckpt_empty  out  1  no checkpoint outstanding
- ex_valid  in  1  ex resolves its oldest outstanding jump (update_en && kind_ex!=0)
- ex_ckpt_id  in  log2(CKPT_NUM)  slot of that jump; always equals the head slot
- ex_mis  in  1  that jump mispredicted (npc or kind)
- ex_kind  in  3  real kind
- ex_ret_pc  in  ADDR_WIDTH  real return address for CALL

## Operation
- State:
  - stack[DEPTH]
  - tos pointer (log2 DEPTH bits, wraps modulo DEPTH)
  - cnt (0..DEPTH, saturating)
  - checkpoint ring of CKPT_NUM entries, each holding {tos, cnt, stack[tos]}, with head/tail pointers plus one extra wrap bit each.
- Fetch action fires when pdc_valid && !stall && !ckpt_full && !(ex_valid && ex_mis) && pdc_kind!=0. It then does the following:
  - Write the checkpoint at tail, capturing the pre-action state.
  - Drive ckpt_id = tail and increment tail.
  - CALL: tos+1, write pdc_ret_pc at the new tos, cnt=min(cnt+1,DEPTH). At cnt==DEPTH this overwrites the oldest entry (wrap).
  - RET: if cnt>0, tos−1 and cnt−1. If cnt==0, the stack is unchanged.
- ex_valid && !ex_mis: increment head (retire).
- ex_valid && ex_mis (recover):
  - Restore tos, cnt and stack[tos] from the checkpoint at ex_ckpt_id.
  - Apply the real effect: CALL pushes ex_ret_pc; RET pops (guarded by cnt>0).
  - Set head = tail = ex_ckpt_id+1, which flushes all younger slots.
- Priority:
  - Recover beats fetch; the fetch action in that cycle is dropped, with no checkpoint and no push/pop.
  - Retire and allocate in the same cycle are both applied.
- ckpt_full = (tail−head==CKPT_NUM). ckpt_empty = (head==tail).
- Reset values:
  - All stack entries 0, tos=0, cnt=0, head=tail=0.
  - Outputs: ret_pdc=0, ret_valid=0, ckpt_id=0, ckpt_full=0, ckpt_empty=1.
  - Reset mid-recover discards everything.

## Timing
- ret_pdc and ret_valid are combinational from the registered stack[tos] and cnt. A push or pop becomes visible the cycle after the action.
- ckpt_id is combinational from tail and valid in the same cycle as pdc_valid.
- Recover completes in 1 cycle. The repaired top is on ret_pdc the following cycle.
- ckpt_full is a registered-state decode. A retire in cycle N frees the slot for allocation in N+1.

## Configuration
- RAS_STATS_EN defined: adds 32-bit output counters, all reset to 0 and incrementing only on effective actions:
  - cnt_push
  - cnt_overflow (CALL at cnt==DEPTH)
  - cnt_pop_empty (RET at cnt==0)
  - cnt_recover
- RAS_STATS_EN undefined: these ports and this logic are absent.

## Structure
- predictor_pkg:
  - Kind constants NOT_JUMP=0, DIRECT_JUMP=1, RET=4, INDIRECT_JUMP=5, CALL=6, JUMP=7.
  - Checkpoint record typedef {tos, cnt, top}.
- One sub-module, ras_ckpt_queue, holds the checkpoint ring and its head/tail/full/empty logic. The stack array and tos/cnt stay in ras_spec.

## Test plan
- Reset, then CALLs pushing 0x100, 0x200, 0x300 → ret_pdc=0x300 and ret_valid=1; 3 RETs → ret_pdc follows 0x200, 0x100, then ret_valid=0.
- DEPTH=16, 17 CALLs pushing 0x1..0x11 → cnt=16; 16 RETs return 0x11 down to 0x2; cnt_overflow=1.
- CALL 0xA (ckpt 0), RET (ckpt 1), CALL 0xB (ckpt 2); ex retires ckpt 0, then resolves ckpt 1 with ex_mis and ex_kind=0 → ret_pdc=0xA, cnt=1, ckpt_empty=1.
- Fill all 8 checkpoints → ckpt_full=1 and a 9th pdc_valid is ignored; retire 1 → next cycle allocation succeeds with ckpt_id=0 (wrap).
- Recover and a fetch CALL 0xC in the same cycle → CALL dropped, ret_pdc equals the restored top, tail=ex_ckpt_id+1.
- RET on empty stack, then CALL 0x5 → ret_pdc=0x5, cnt=1, cnt_pop_empty=1.
